// File: rtl/control_unit.sv
// control_unit: multi-cycle FSM sequencer for the datapath, with a retired-instruction counter
module control_unit #(
  parameter logic [5:0] HALT_OPCODE = 6'h3F,
  parameter int         CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             pc_load,
  output logic             ir_load,
  output logic             mem_r,
  output logic             mem_w,
  output logic             rf_r,
  output logic             rf_w,
  output logic [1:0]       pc_sel,
  output logic [5:0]       alu_op,
  output logic             alu_src,
  output logic [1:0]       wb_sel,
  output logic [1:0]       rd_sel,
  output logic [2:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXE    = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd7
  } state_t;
  state_t st, nx;
  logic [5:0] r_op, i_op, alu_dec;
  logic is_r, is_lw, is_sw, is_beq, is_bne, is_jmp, is_jal, is_jr, is_lui;
  logic r_alu, i_alu, dec_src;
  assign is_r   = opcode == 6'h00;
  assign is_lw  = opcode == 6'h23;
  assign is_sw  = opcode == 6'h2B;
  assign is_beq = opcode == 6'h04;
  assign is_bne = opcode == 6'h05;
  assign is_jmp = opcode == 6'h02;
  assign is_jal = opcode == 6'h03;
  assign is_lui = opcode == 6'h0F;
  assign is_jr  = is_r && funct == 6'h08;
  assign r_alu  = is_r && r_op != 6'd0;
  assign alu_dec = is_r ? r_op : i_op;
  assign dec_src = i_alu | is_lw | is_sw;
  assign state  = st;
  assign halted = st == HALT;
  // R-type function field to ALU code; zero means not an ALU function
  always_comb begin
    case (funct)
      6'h20:   r_op = 6'd1;
      6'h22:   r_op = 6'd2;
      6'h2C:   r_op = 6'd3;
      6'h02:   r_op = 6'd4;
      6'h01:   r_op = 6'd5;
      6'h24:   r_op = 6'd6;
      6'h25:   r_op = 6'd7;
      6'h27:   r_op = 6'd8;
      6'h2A:   r_op = 6'd9;
      default: r_op = 6'd0;
    endcase
  end
  // I-type opcode to ALU code; memory ops add, branches subtract
  always_comb begin
    i_alu = 1'b1;
    case (opcode)
      6'h08:   i_op = 6'd1;
      6'h1D:   i_op = 6'd3;
      6'h0C:   i_op = 6'd6;
      6'h0D:   i_op = 6'd7;
      6'h0A:   i_op = 6'd9;
      default: i_op = 6'd0;
    endcase
    if (i_op == 6'd0) i_alu = 1'b0;
    if (is_lw || is_sw) i_op = 6'd1;
    if (is_beq || is_bne) i_op = 6'd2;
  end
  // state register; reset aborts any instruction and returns to FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= FETCH;
    else st <= nx;
  end
  // retirement counter advances as each instruction leaves WB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retired <= '0;
    else if (st == WB) retired <= retired + CNT_W'(1);
  end
  // next state and per-state controls; everything is silenced while reset is held
  always_comb begin
    nx = st;
    pc_load = 1'b0;
    ir_load = 1'b0;
    mem_r = 1'b0;
    mem_w = 1'b0;
    rf_r = 1'b0;
    rf_w = 1'b0;
    pc_sel = 2'd0;
    alu_op = 6'd0;
    alu_src = 1'b0;
    wb_sel = 2'd0;
    rd_sel = 2'd0;
    if (rst_n) begin
      case (st)
        FETCH: begin
          mem_r = 1'b1;
          ir_load = 1'b1;
          nx = DECODE;
        end
        DECODE: begin
          rf_r = 1'b1;
          nx = opcode == HALT_OPCODE ? HALT : EXE;
        end
        EXE: begin
          alu_op = alu_dec;
          alu_src = dec_src;
          nx = MEM;
        end
        MEM: begin
          alu_op = alu_dec;
          alu_src = dec_src;
          mem_r = is_lw;
          mem_w = is_sw;
          nx = WB;
        end
        WB: begin
          pc_load = 1'b1;
          rf_w = r_alu | i_alu | is_lui | is_lw | is_jal;
          pc_sel = (is_beq && zero) || (is_bne && !zero) ? 2'd1 :
                   (is_jmp || is_jal) ? 2'd2 : is_jr ? 2'd3 : 2'd0;
          wb_sel = is_lw ? 2'd1 : is_lui ? 2'd2 : is_jal ? 2'd3 : 2'd0;
          rd_sel = is_jal ? 2'd2 : (i_alu || is_lui || is_lw) ? 2'd1 : 2'd0;
          nx = FETCH;
        end
        HALT: nx = HALT;
        default: nx = FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed self-checking bench for control_unit
module tb_control_unit;
  logic clk = 1'b0;
  logic rst_n;
  logic [5:0] opcode, funct;
  logic zero;
  logic pc_load, ir_load, mem_r, mem_w, rf_r, rf_w, alu_src, halted;
  logic [1:0] pc_sel, wb_sel, rd_sel;
  logic [5:0] alu_op;
  logic [2:0] state;
  logic [3:0] retired;
  int total = 0;
  int passed = 0;

  control_unit #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_load(pc_load), .ir_load(ir_load), .mem_r(mem_r), .mem_w(mem_w),
    .rf_r(rf_r), .rf_w(rf_w), .pc_sel(pc_sel), .alu_op(alu_op),
    .alu_src(alu_src), .wb_sel(wb_sel), .rd_sel(rd_sel), .state(state),
    .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    total++;
    assert (obs === req) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
  endtask

  task automatic go(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [5:0] strobes();
    return {pc_load, ir_load, mem_r, mem_w, rf_r, rf_w};
  endfunction

  initial begin
    rst_n = 1'b0;
    opcode = 6'h00;
    funct = 6'h20;
    zero = 1'b0;
    #3;
    chk("rst_state", state, 0);
    chk("rst_retired", retired, 0);
    chk("rst_halted", halted, 0);
    chk("rst_strobes", strobes(), 0);
    #9 rst_n = 1'b1;
    #1;
    chk("add_fetch_state", state, 0);
    chk("add_fetch_strobes", strobes(), 6'b011000);
    go(1);
    chk("add_decode_state", state, 1);
    chk("add_decode_strobes", strobes(), 6'b000010);
    go(1);
    chk("add_exe_state", state, 2);
    chk("add_exe_aluop", alu_op, 1);
    chk("add_exe_alusrc", alu_src, 0);
    go(1);
    chk("add_mem_state", state, 3);
    chk("add_mem_strobes", strobes(), 0);
    go(1);
    chk("add_wb_state", state, 4);
    chk("add_wb_strobes", strobes(), 6'b100001);
    chk("add_wb_pcsel", pc_sel, 0);
    chk("add_wb_rdsel", rd_sel, 0);
    go(1);
    chk("add_done_state", state, 0);
    chk("add_retired", retired, 1);
    opcode = 6'h04; zero = 1'b1;
    go(4);
    chk("beq_z1_pcsel", pc_sel, 1);
    go(1);
    zero = 1'b0;
    go(4);
    chk("beq_z0_pcsel", pc_sel, 0);
    go(1);
    opcode = 6'h05; zero = 1'b1;
    go(2);
    chk("bne_exe_aluop", alu_op, 2);
    go(2);
    chk("bne_z1_pcsel", pc_sel, 0);
    go(1);
    zero = 1'b0;
    go(4);
    chk("bne_z0_pcsel", pc_sel, 1);
    go(1);
    chk("branch_retired", retired, 5);
    opcode = 6'h23;
    go(3);
    chk("lw_mem_strobes", strobes(), 6'b001000);
    go(1);
    chk("lw_wb_rfw", rf_w, 1);
    chk("lw_wb_wbsel", wb_sel, 1);
    chk("lw_wb_rdsel", rd_sel, 1);
    go(1);
    opcode = 6'h2B;
    go(2);
    chk("sw_exe_aluop", alu_op, 1);
    chk("sw_exe_alusrc", alu_src, 1);
    go(1);
    chk("sw_mem_strobes", strobes(), 6'b000100);
    go(1);
    chk("sw_wb_strobes", strobes(), 6'b100000);
    go(1);
    opcode = 6'h03;
    go(4);
    chk("jal_pcsel", pc_sel, 2);
    chk("jal_wbsel", wb_sel, 3);
    chk("jal_rdsel", rd_sel, 2);
    chk("jal_rfw", rf_w, 1);
    go(1);
    opcode = 6'h00; funct = 6'h08;
    go(4);
    chk("jr_pcsel", pc_sel, 3);
    chk("jr_rfw", rf_w, 0);
    go(1);
    opcode = 6'h3E;
    go(4);
    chk("nop_wb_strobes", strobes(), 6'b100000);
    chk("nop_pcsel", pc_sel, 0);
    go(1);
    opcode = 6'h1D;
    go(2);
    chk("muli_aluop", alu_op, 3);
    chk("muli_alusrc", alu_src, 1);
    go(2);
    chk("muli_rdsel", rd_sel, 1);
    go(1);
    opcode = 6'h0F;
    go(4);
    chk("lui_wbsel", wb_sel, 2);
    chk("lui_rfw", rf_w, 1);
    go(1);
    chk("mix_retired", retired, 12);
    opcode = 6'h2B;
    go(3);
    chk("sw2_mem_w", mem_w, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_mem_w", mem_w, 0);
    chk("abort_state", state, 0);
    chk("abort_retired", retired, 0);
    #1 rst_n = 1'b1;
    go(1);
    chk("restart_state", state, 1);
    go(4);
    chk("restart_retired", retired, 1);
    opcode = 6'h00; funct = 6'h20;
    go(70);
    chk("preload_retired", retired, 15);
    go(5);
    chk("wrap_retired", retired, 0);
    opcode = 6'h3F;
    go(2);
    chk("halt_state", state, 7);
    chk("halt_flag", halted, 1);
    for (int i = 0; i < 20; i++) begin
      go(1);
      chk("halt_hold", {state, halted, strobes(), retired}, {3'd7, 1'b1, 6'd0, 4'd0});
    end
    #2 rst_n = 1'b0;
    #1;
    chk("halt_rst_state", state, 0);
    chk("halt_rst_flag", halted, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter HALT_OPCODE, default 6'h3F, SHALL be the opcode that stops instruction sequencing.
REQ-002 Parameter CNT_W, default 32, SHALL be the width of the retired-instruction counter.
REQ-003 CLK  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 RST  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 OPCODE  input  6  SHALL carry IR[31:26] from the datapath.
REQ-006 FUNCT  input  6  SHALL carry IR[5:0] from the datapath.
REQ-007 ZERO  input  1  SHALL carry the ALU zero flag.
REQ-008 PC_LOAD, IR_LOAD, MEM_R, MEM_W, RF_R, RF_W  output  1 each  SHALL be the strobes for PC load, IR load, memory read/write and register-file read/write.
REQ-009 PC_SEL  output  2  SHALL select the next PC: 0=PC+1, 1=branch target (PC+1+sign-extended imm), 2=jump address {PC[31:26],addr}, 3=register rs.
REQ-010 ALU_OP  output  6  SHALL carry the ALU code: 1 add, 2 sub, 3 mul, 4 srl, 5 sll, 6 and, 7 or, 8 nor, 9 slt.
REQ-011 ALU_SRC  output  1  SHALL select operand 2: 0=rt, 1=extended imm.
REQ-012 WB_SEL  output  2  SHALL select write-back data: 0=ALU, 1=memory, 2={imm,16'h0}, 3=PC+1. RD_SEL output 2: 0=rd, 1=rt, 2=r31.
REQ-013 STATE  output  3  SHALL expose the FSM state. HALTED output 1. RETIRED output CNT_W.

Function
REQ-014 FSM states SHALL be: FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4, HALT=7.
REQ-015 Transitions SHALL be FETCH->DECODE->EXE->MEM->WB->FETCH, unconditionally, one cycle each; every instruction takes exactly 5 cycles.
REQ-016 DECODE SHALL go to HALT, not EXE, when OPCODE==HALT_OPCODE; HALT SHALL be exited only by reset.
REQ-017 FETCH: MEM_R=1, IR_LOAD=1; all other strobes 0.
REQ-018 DECODE: RF_R=1; other strobes 0.
REQ-019 EXE: ALU_OP/ALU_SRC driven per decode (R-type opcode 0: FUNCT 20 add, 22 sub, 2C mul, 02 srl, 01 sll, 24 and, 25 or, 27 nor, 2A slt; I-type: 08 addi, 1D muli, 0C andi, 0D ori, 0A slti, 23 lw / 2B sw use add, 04 beq / 05 bne use sub).
REQ-020 MEM: MEM_R=1 for lw, MEM_W=1 for sw; no strobe otherwise; ALU controls held from EXE.
REQ-021 WB: RF_W=1 for R-type ALU ops, I-type ALU ops, lui (0F), lw, jal (03); PC_LOAD=1 for every legal instruction.
REQ-022 PC_SEL in WB SHALL be 1 for beq with ZERO=1 and bne with ZERO=0, 2 for jmp (02) and jal, 3 for jr (opcode 0, FUNCT 08), else 0.
REQ-023 Outputs SHALL be combinational from registered state plus OPCODE/FUNCT/ZERO; only state and RETIRED are registered.
REQ-024 Unrecognised opcode/funct SHALL be a NOP: no RF_W/MEM_W, PC_LOAD=1 with PC_SEL=0 in WB.
REQ-025 RETIRED SHALL increment by 1 at each WB->FETCH edge and wrap from all-ones to 0.
REQ-026 HALT: all strobes 0, HALTED=1, RETIRED frozen.

Reset
REQ-027 RST low SHALL force, without waiting for CLK, STATE=FETCH, RETIRED=0, HALTED=0, and drive all strobes to 0 while asserted.
REQ-028 Reset asserted mid-instruction (any state) SHALL abort it with no further strobes; first rising CLK after release executes FETCH.

Verification
REQ-029 Reset release, OPCODE=00/FUNCT=20 -> states 0,1,2,3,4,0; ALU_OP=1 in EXE; RF_W=1, PC_LOAD=1, PC_SEL=0 in WB; RETIRED=1.
REQ-030 beq (04) with ZERO=1 -> WB PC_SEL=1; repeat with ZERO=0 -> PC_SEL=0; bne inverse.
REQ-031 lw (23) -> MEM_R=1 in MEM, WB_SEL=1, RD_SEL=1, RF_W=1; sw (2B) -> MEM_W=1 in MEM, RF_W=0 in WB.
REQ-032 jal (03) -> WB PC_SEL=2, WB_SEL=3, RD_SEL=2, RF_W=1; jr -> PC_SEL=3, RF_W=0.
REQ-033 OPCODE=3F at DECODE -> STATE=7, HALTED=1, strobes 0 for 20 cycles, RETIRED unchanged; RST low -> STATE=0 immediately.
REQ-034 RST pulsed low between clock edges during MEM of sw -> MEM_W drops at once, RETIRED=0, restart at FETCH; RETIRED preloaded via 2^CNT_W-1 retirements (CNT_W=4: 15) wraps to 0.
